// File: rtl/tmds_encoder_dvi.sv
// Three-channel DVI TMDS 8b/10b encoder with DC balancing, two-stage pipeline in the vgaclk domain.
// Optional macro TMDS_OUT_REG_EN adds a third output register stage (latency 3 instead of 2).
module tmds_encoder_dvi #(
   parameter bit          SYNC_INV  = 1'b0,
   parameter int unsigned CNT_WIDTH = 5
) (
   input  logic       vgaclk,
   input  logic       reset,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   input  logic       blank,
   input  logic       hsync,
   input  logic       vsync,
   output logic [9:0] tmds_r,
   output logic [9:0] tmds_g,
   output logic [9:0] tmds_b
);

   localparam int unsigned NUM_CH = 3;
   localparam logic [9:0]  CTL_00 = 10'b1101010100;
   localparam logic [9:0]  CTL_01 = 10'b0010101011;
   localparam logic [9:0]  CTL_10 = 10'b0101010100;
   localparam logic [9:0]  CTL_11 = 10'b1010101011;

   typedef logic signed [CNT_WIDTH-1:0] cnt_t;

   // Transition-minimising stage: XOR or XNOR chain, q_m[8] records which was used.
   function automatic logic [8:0] tmds_qm(input logic [7:0] d);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] q;
      n1       = 4'($countones(d));
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      q        = '0;
      q[0]     = d[0];
      for (int i = 1; i < 8; i++) begin
         q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      end
      q[8] = ~use_xnor;
      return q;
   endfunction

   function automatic logic [9:0] ctl_code(input logic [1:0] c);
      logic [9:0] w;
      case (c)
         2'b01:   w = CTL_01;
         2'b10:   w = CTL_10;
         2'b11:   w = CTL_11;
         default: w = CTL_00;
      endcase
      return w;
   endfunction

   logic [NUM_CH-1:0][7:0] d_in;
   logic [NUM_CH-1:0][9:0] word_s2;
   logic                   blank_s1;
   logic                   c0_s1;
   logic                   c1_s1;

   // Channel order: 0 = blue (carries syncs), 1 = green, 2 = red.
   assign d_in = {red, green, blue};

   // Shared control path; reset flushes it to a blank word with both syncs low.
   always_ff @(posedge vgaclk) begin
      if (reset) begin
         blank_s1 <= 1'b1;
         c0_s1    <= 1'b0;
         c1_s1    <= 1'b0;
      end else begin
         blank_s1 <= blank;
         c0_s1    <= hsync ^ SYNC_INV;
         c1_s1    <= vsync ^ SYNC_INV;
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [8:0] qm_s1;
      logic [3:0] n1_s1;
      logic [1:0] ctl;
      logic [9:0] word_c;
      logic [9:0] word_q;
      cnt_t       cnt_q;
      cnt_t       cnt_nxt;
      cnt_t       n1s;
      cnt_t       n0s;
      cnt_t       two_q8;
      cnt_t       two_nq8;

      assign ctl = (ch == 0) ? {c1_s1, c0_s1} : 2'b00;

      // Stage 1: register q_m and its ones count.
      always_ff @(posedge vgaclk) begin
         if (reset) begin
            qm_s1 <= '0;
            n1_s1 <= '0;
         end else begin
            qm_s1 <= tmds_qm(d_in[ch]);
            n1_s1 <= 4'($countones(tmds_qm(d_in[ch]) & 9'h0FF));
         end
      end

      // Stage 2: DC balance against the running disparity.
      always_comb begin
         n1s     = cnt_t'(n1_s1);
         n0s     = cnt_t'(4'd8 - n1_s1);
         two_q8  = qm_s1[8] ? cnt_t'(2) : cnt_t'(0);
         two_nq8 = qm_s1[8] ? cnt_t'(0) : cnt_t'(2);
         word_c  = CTL_00;
         cnt_nxt = cnt_q;
         if (blank_s1) begin
            word_c  = ctl_code(ctl);
            cnt_nxt = cnt_t'(0);
         end else if ((cnt_q == cnt_t'(0)) || (n1_s1 == 4'd4)) begin
            word_c  = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
            cnt_nxt = qm_s1[8] ? (cnt_q + n1s - n0s) : (cnt_q + n0s - n1s);
         end else if (((cnt_q > cnt_t'(0)) && (n1s > n0s)) ||
                      ((cnt_q < cnt_t'(0)) && (n0s > n1s))) begin
            word_c  = {1'b1, qm_s1[8], ~qm_s1[7:0]};
            cnt_nxt = cnt_q + two_q8 + n0s - n1s;
         end else begin
            word_c  = {1'b0, qm_s1[8], qm_s1[7:0]};
            cnt_nxt = cnt_q + n1s - n0s - two_nq8;
         end
      end

      always_ff @(posedge vgaclk) begin
         if (reset) begin
            word_q <= CTL_00;
            cnt_q  <= cnt_t'(0);
         end else begin
            word_q <= word_c;
            cnt_q  <= cnt_nxt;
         end
      end

      assign word_s2[ch] = word_q;
   end

`ifdef TMDS_OUT_REG_EN
   logic [NUM_CH-1:0][9:0] word_s3;

   // Retiming stage in front of the serializer.
   always_ff @(posedge vgaclk) begin
      if (reset) begin
         word_s3 <= {NUM_CH{CTL_00}};
      end else begin
         word_s3 <= word_s2;
      end
   end

   assign tmds_b = word_s3[0];
   assign tmds_g = word_s3[1];
   assign tmds_r = word_s3[2];
`else
   assign tmds_b = word_s2[0];
   assign tmds_g = word_s2[1];
   assign tmds_r = word_s2[2];
`endif

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Scoreboard bench for tmds_encoder_dvi: the driver queues hand-computed words, the monitor
// pops and compares them when they are due at the outputs.
module tb_tmds_encoder_dvi;

`ifdef TMDS_OUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   localparam logic [9:0] C00  = 10'b1101010100;
   localparam logic [9:0] C01  = 10'b0010101011;
   localparam logic [9:0] C10  = 10'b0101010100;
   localparam logic [9:0] C11  = 10'b1010101011;
   localparam logic [9:0] P00A = 10'b0100000000;  // 00 with no inversion
   localparam logic [9:0] P00B = 10'b1111111111;  // 00 inverted
   localparam logic [9:0] PFFA = 10'b1000000000;  // FF inverted
   localparam logic [9:0] PFFC = 10'b0011111111;  // FF, XNOR, not inverted
   localparam logic [9:0] G0FA = 10'b0100000101;
   localparam logic [9:0] G0FB = 10'b1111111010;
   localparam logic [9:0] R55  = 10'b0100110011;

   typedef struct {
      logic [9:0] r;
      logic [9:0] g;
      logic [9:0] b;
      string      tag;
   } exp_t;

   logic       vgaclk = 1'b0;
   logic       reset  = 1'b1;
   logic [7:0] red    = '0;
   logic [7:0] green  = '0;
   logic [7:0] blue   = '0;
   logic       blank  = 1'b1;
   logic       hsync  = 1'b0;
   logic       vsync  = 1'b0;
   logic [9:0] tmds_r;
   logic [9:0] tmds_g;
   logic [9:0] tmds_b;

   exp_t           exp_q[$];
   logic           stim_chk = 1'b0;
   logic [LAT-1:0] chk_pipe = '0;
   logic           now_chk  = 1'b0;
   int             n_pass   = 0;
   int             n_total  = 0;

   tmds_encoder_dvi dut (
      .vgaclk (vgaclk),
      .reset  (reset),
      .red    (red),
      .green  (green),
      .blue   (blue),
      .blank  (blank),
      .hsync  (hsync),
      .vsync  (vsync),
      .tmds_r (tmds_r),
      .tmds_g (tmds_g),
      .tmds_b (tmds_b)
   );

   always #20 vgaclk = ~vgaclk;

   // Tracks when each queued word is due: LAT edges normally, immediately for a reset cycle.
   always @(posedge vgaclk) begin
      if (reset) begin
         chk_pipe <= '0;
         now_chk  <= stim_chk;
      end else begin
         chk_pipe <= {chk_pipe[LAT-2:0], stim_chk};
         now_chk  <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   always @(negedge vgaclk) begin
      if (chk_pipe[LAT-1] || now_chk) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_empty: got output with no expected word, expected a queued entry");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, "/b"}, tmds_b, e.b);
            check({e.tag, "/g"}, tmds_g, e.g);
            check({e.tag, "/r"}, tmds_r, e.r);
         end
      end
   end

   task automatic step(input logic rst, input logic bl, input logic hs, input logic vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [9:0] er, input logic [9:0] eg, input logic [9:0] eb,
                       input logic chk, input string tag);
      exp_t e;
      @(negedge vgaclk);
      reset    = rst;
      blank    = bl;
      hsync    = hs;
      vsync    = vs;
      red      = r;
      green    = g;
      blue     = b;
      stim_chk = chk;
      if (chk) begin
         e.r = er; e.g = eg; e.b = eb; e.tag = tag;
         exp_q.push_back(e);
      end
   endtask

   initial begin
      // reset, control codes (pixel data must be ignored while blank)
      step(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, C00, C00, C00, 1, "rst0");
      step(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, C00, C00, C00, 1, "rst1");
      step(0, 1, 0, 0, 8'hA5, 8'h5A, 8'hFF, C00, C00, C00, 1, "ctl00");
      step(0, 1, 1, 0, 8'hA5, 8'h5A, 8'hFF, C00, C00, C01, 1, "ctl01");
      step(0, 1, 1, 1, 8'hA5, 8'h5A, 8'hFF, C00, C00, C11, 1, "ctl11");
      step(0, 1, 0, 1, 8'hA5, 8'h5A, 8'hFF, C00, C00, C10, 1, "ctl10");
      // active line starting from cnt 0
      step(0, 0, 0, 0, 8'h55, 8'h0F, 8'h00, R55, G0FA, P00A, 1, "pix1");
      step(0, 0, 0, 0, 8'h55, 8'h0F, 8'h00, R55, G0FB, P00B, 1, "pix2");
      step(0, 0, 0, 0, 8'h55, 8'h0F, 8'h00, R55, G0FA, P00A, 1, "pix3");
      // one-clock blank clears the counters
      step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, C00, C00, C00, 1, "blank1");
      step(0, 0, 0, 0, 8'hFF, 8'h00, 8'hFF, PFFA, P00A, PFFA, 1, "ff1");
      step(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, C00, C00, C01, 1, "blank2");
      step(0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, P00A, P00A, PFFA, 1, "ff2");
      // walk every balance branch, including the q_m[8]=0 else path
      step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, P00B, P00B, P00B, 1, "seq1");
      step(0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, P00A, P00A, PFFA, 1, "seq2");
      step(0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, P00B, P00B, PFFC, 1, "seq3");
      step(0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, P00A, P00A, PFFA, 1, "seq4");
      step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, C00, C00, C00, 1, "blank3");
      // mid-line reset: words still in flight at the reset edge are dropped
      for (int i = 0; i < 3; i++) begin
         logic [9:0] ew;
         ew = (i == 1) ? P00B : P00A;
         step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, ew, ew, ew, logic'(i < 4 - LAT),
              $sformatf("mid%0d", i));
      end
      step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, C00, C00, C00, 1, "midrst");
      step(0, 0, 0, 0, 8'h00, 8'h0F, 8'h00, P00A, G0FA, P00A, 1, "post");
      step(0, 1, 1, 1, 8'h00, 8'h00, 8'h00, C00, C00, C11, 1, "ctl_end");
      step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, C00, C00, C00, 0, "idle");
      repeat (LAT + 2) @(negedge vgaclk);
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d words still queued, expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
